// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with a fixed slave access time.
// One owner per transaction; each transaction runs IDLE -> BUSY (WAIT_CYCLES+1) -> ACK.
module bus_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m1_wdata,
  input  logic        m0_we,
  input  logic        m1_we,
  output logic        m0_ack,
  output logic        m1_ack,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic [1:0]  gnt,
  output logic [31:0] bc_addr,
  output logic [31:0] bc_data,
  output logic        bc_we,
  input  logic [31:0] s_rdata
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_owner;   // 0 = m0, 1 = m1
  logic                r_we;
  logic                r_last;    // last granted master, 1 = m1
  logic [DATA_W-1:0]   r_bc_addr;
  logic [DATA_W-1:0]   r_bc_data;
  logic [1:0]          r_gnt;
  logic                r_bc_we;
  logic                r_m0_ack;
  logic                r_m1_ack;
  logic [DATA_W-1:0]   r_m0_rdata;
  logic [DATA_W-1:0]   r_m1_rdata;

  state_t              w_state_nx;
  logic [CNT_W-1:0]    w_cnt_nx;
  logic                w_owner_nx;
  logic                w_we_nx;
  logic                w_last_nx;
  logic [DATA_W-1:0]   w_addr_nx;
  logic [DATA_W-1:0]   w_data_nx;
  logic                w_cap0;
  logic                w_cap1;
  logic [1:0]          w_gnt_nx;
  logic                w_bc_we_nx;
  logic                w_m0_ack_nx;
  logic                w_m1_ack_nx;

  // Next state plus next values of the registered outputs, so outputs line up with the state.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_owner_nx = r_owner;
    w_we_nx    = r_we;
    w_last_nx  = r_last;
    w_addr_nx  = r_bc_addr;
    w_data_nx  = r_bc_data;
    w_cap0     = 1'b0;
    w_cap1     = 1'b0;

    case (r_state)
      IDLE: begin
        if (m0_req || m1_req) begin
          // On a tie the master that did not win last time gets the bus.
          w_owner_nx = (m0_req && m1_req) ? ~r_last : m1_req;
          w_addr_nx  = w_owner_nx ? m1_addr  : m0_addr;
          w_data_nx  = w_owner_nx ? m1_wdata : m0_wdata;
          w_we_nx    = w_owner_nx ? m1_we    : m0_we;
          w_cnt_nx   = CNT_W'(WAIT_CYCLES);
          w_state_nx = BUSY;
        end
      end
      BUSY: begin
        if (r_cnt == '0) begin
          w_state_nx = ACK;
          w_cap0     = !r_we && !r_owner;
          w_cap1     = !r_we &&  r_owner;
        end else begin
          w_cnt_nx = r_cnt - CNT_W'(1);
        end
      end
      ACK: begin
        w_last_nx  = r_owner;
        w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase

    w_gnt_nx    = (w_state_nx != IDLE) ? (w_owner_nx ? 2'b10 : 2'b01) : 2'b00;
    w_bc_we_nx  = (w_state_nx == BUSY) && (w_cnt_nx == '0) && w_we_nx;
    w_m0_ack_nx = (w_state_nx == ACK) && !w_owner_nx;
    w_m1_ack_nx = (w_state_nx == ACK) &&  w_owner_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_owner    <= 1'b0;
      r_we       <= 1'b0;
      r_last     <= 1'b1;
      r_bc_addr  <= '0;
      r_bc_data  <= '0;
      r_gnt      <= 2'b00;
      r_bc_we    <= 1'b0;
      r_m0_ack   <= 1'b0;
      r_m1_ack   <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_owner   <= w_owner_nx;
      r_we      <= w_we_nx;
      r_last    <= w_last_nx;
      r_bc_addr <= w_addr_nx;
      r_bc_data <= w_data_nx;
      r_gnt     <= w_gnt_nx;
      r_bc_we   <= w_bc_we_nx;
      r_m0_ack  <= w_m0_ack_nx;
      r_m1_ack  <= w_m1_ack_nx;
      if (w_cap0) r_m0_rdata <= s_rdata;
      if (w_cap1) r_m1_rdata <= s_rdata;
    end
  end

  assign gnt      = r_gnt;
  assign bc_we    = r_bc_we;
  assign bc_addr  = r_bc_addr;
  assign bc_data  = r_bc_data;
  assign m0_ack   = r_m0_ack;
  assign m1_ack   = r_m1_ack;
  assign m0_rdata = r_m0_rdata;
  assign m1_rdata = r_m1_rdata;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed + random bench for bus_arbiter; expected behaviour comes from a
// transaction-level model (round-robin winner, fixed latency, per-master read data).
module tb_bus_arbiter;

  localparam int unsigned WC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        m0_req, m1_req, m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, s_rdata;
  logic        m0_ack, m1_ack, bc_we;
  logic [31:0] m0_rdata, m1_rdata, bc_addr, bc_data;
  logic [1:0]  gnt;

  logic        z_m0_req, z_m0_we;
  logic [31:0] z_m0_addr, z_m0_wdata, z_s_rdata;
  logic        z_m0_ack, z_m1_ack, z_bc_we;
  logic [31:0] z_m0_rdata, z_m1_rdata, z_bc_addr, z_bc_data;
  logic [1:0]  z_gnt;

  bus_arbiter #(.WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m1_req(m1_req),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_we(m0_we), .m1_we(m1_we),
    .m0_ack(m0_ack), .m1_ack(m1_ack),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .gnt(gnt), .bc_addr(bc_addr), .bc_data(bc_data), .bc_we(bc_we),
    .s_rdata(s_rdata)
  );

  bus_arbiter #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .m0_req(z_m0_req), .m1_req(1'b0),
    .m0_addr(z_m0_addr), .m1_addr(32'h0),
    .m0_wdata(z_m0_wdata), .m1_wdata(32'h0),
    .m0_we(z_m0_we), .m1_we(1'b0),
    .m0_ack(z_m0_ack), .m1_ack(z_m1_ack),
    .m0_rdata(z_m0_rdata), .m1_rdata(z_m1_rdata),
    .gnt(z_gnt), .bc_addr(z_bc_addr), .bc_data(z_bc_data), .bc_we(z_bc_we),
    .s_rdata(z_s_rdata)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: last winner (1 = m1) and each master's read-data register.
  bit          m_last;
  logic [31:0] m_rd [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Starts in an IDLE cycle, ends in the IDLE cycle after ACK.
  task automatic txn(input bit r0, input bit r1,
                     input logic [31:0] a0, input logic [31:0] d0, input bit w0,
                     input logic [31:0] a1, input logic [31:0] d1, input bit w1,
                     input logic [31:0] srd, input bit hold, input bit mid);
    bit          win;
    bit          ew;
    logic [31:0] ea, ed;
    logic [1:0]  eg;
    win = (r0 && r1) ? !m_last : r1;
    ea  = win ? a1 : a0;
    ed  = win ? d1 : d0;
    ew  = win ? w1 : w0;
    eg  = win ? 2'b10 : 2'b01;
    m0_req = r0; m0_addr = a0; m0_wdata = d0; m0_we = w0;
    m1_req = r1; m1_addr = a1; m1_wdata = d1; m1_we = w1;
    s_rdata = srd;
    cyc();
    for (int i = 0; i <= int'(WC); i++) begin
      check("busy_gnt", 32'(gnt), 32'(eg));
      check("busy_bc_we", 32'(bc_we), 32'(ew && (i == int'(WC))));
      check("busy_bc_addr", bc_addr, ea);
      check("busy_bc_data", bc_data, ed);
      check("busy_ack", 32'({m1_ack, m0_ack}), 32'h0);
      if (mid && i == 0) begin
        m0_req = 1'b0; m1_req = 1'b0;
        m0_addr = ~a0; m0_wdata = d0 + 32'd1; m0_we = ~w0;
        m1_addr = ~a1; m1_wdata = d1 + 32'd1; m1_we = ~w1;
      end
      cyc();
    end
    if (!ew) m_rd[win] = srd;
    if (!hold) begin
      m0_req = 1'b0;
      m1_req = 1'b0;
    end
    check("ack_pulse", 32'({m1_ack, m0_ack}), 32'(eg));
    check("ack_gnt", 32'(gnt), 32'(eg));
    check("ack_bc_we", 32'(bc_we), 32'h0);
    check("ack_m0_rdata", m0_rdata, m_rd[0]);
    check("ack_m1_rdata", m1_rdata, m_rd[1]);
    m_last = win;
    cyc();
    check("idle_gnt", 32'(gnt), 32'h0);
    check("idle_ack", 32'({m1_ack, m0_ack}), 32'h0);
    check("idle_bc_we", 32'(bc_we), 32'h0);
    check("idle_bc_addr_hold", bc_addr, ea);
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
    m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0; s_rdata = 0;
    z_m0_req = 0; z_m0_we = 0; z_m0_addr = 0; z_m0_wdata = 0; z_s_rdata = 0;
    m_last = 1'b1;
    m_rd[0] = '0;
    m_rd[1] = '0;

    // Reset values
    cyc(); cyc();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_ack", 32'({m1_ack, m0_ack}), 32'h0);
    check("rst_bc_we", 32'(bc_we), 32'h0);
    check("rst_bc_addr", bc_addr, 32'h0);
    check("rst_bc_data", bc_data, 32'h0);
    check("rst_m0_rdata", m0_rdata, 32'h0);
    check("rst_m1_rdata", m1_rdata, 32'h0);
    rst = 1'b0;
    cyc();

    // Zero wait cycles: one BUSY cycle then ACK
    z_m0_req = 1; z_m0_we = 1; z_m0_addr = 32'h0000_0040; z_m0_wdata = 32'h0000_0077;
    cyc();
    check("w0_busy_gnt", 32'(z_gnt), 32'h1);
    check("w0_busy_bc_we", 32'(z_bc_we), 32'h1);
    check("w0_busy_bc_addr", z_bc_addr, 32'h0000_0040);
    check("w0_busy_bc_data", z_bc_data, 32'h0000_0077);
    z_m0_req = 0;
    cyc();
    check("w0_ack", 32'({z_m1_ack, z_m0_ack}), 32'h1);
    check("w0_ack_bc_we", 32'(z_bc_we), 32'h0);
    cyc();
    check("w0_idle_gnt", 32'(z_gnt), 32'h0);
    z_m0_req = 1; z_m0_we = 0; z_s_rdata = 32'hCAFE_0001;
    cyc();
    check("w0_rd_bc_we", 32'(z_bc_we), 32'h0);
    z_m0_req = 0;
    cyc();
    check("w0_rd_ack", 32'(z_m0_ack), 32'h1);
    check("w0_rd_data", z_m0_rdata, 32'hCAFE_0001);
    cyc();

    // m0 write
    txn(1, 0, 32'hFFFF_FF00, 32'h0000_00A5, 1, 32'h0, 32'h0, 0, 32'h5555_5555, 0, 0);
    // m1 read
    txn(0, 1, 32'h0, 32'h0, 0, 32'h0000_0010, 32'h0, 0, 32'h1234_5678, 0, 0);
    // Continuous tie: alternating grants
    txn(1, 1, 32'h100, 32'h1, 0, 32'h200, 32'h2, 0, 32'hA0A0_0001, 1, 0);
    check("rr_first_m0", 32'(m_last), 32'h0);
    txn(1, 1, 32'h100, 32'h1, 0, 32'h200, 32'h2, 0, 32'hA0A0_0002, 1, 0);
    check("rr_second_m1", 32'(m_last), 32'h1);
    txn(1, 1, 32'h100, 32'h1, 0, 32'h200, 32'h2, 0, 32'hA0A0_0003, 1, 0);
    txn(1, 1, 32'h100, 32'h1, 0, 32'h200, 32'h2, 0, 32'hA0A0_0004, 0, 0);
    // Inputs change and req drops mid-transaction
    txn(1, 0, 32'h0000_3000, 32'h0000_0BEE, 1, 32'h0, 32'h0, 0, 32'h0, 0, 1);

    // Reset in the 2nd BUSY cycle of an m1 write
    m1_req = 1; m1_we = 1; m1_addr = 32'h0000_0400; m1_wdata = 32'h0000_00C3;
    cyc();
    check("abort_busy1_gnt", 32'(gnt), 32'h2);
    check("abort_busy1_bc_we", 32'(bc_we), 32'h0);
    cyc();
    check("abort_busy2_bc_we", 32'(bc_we), 32'h0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    m1_req = 0;
    m_last = 1'b1;
    m_rd[0] = '0;
    m_rd[1] = '0;
    check("abort_gnt", 32'(gnt), 32'h0);
    check("abort_ack", 32'({m1_ack, m0_ack}), 32'h0);
    check("abort_bc_we", 32'(bc_we), 32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("abort_quiet_ack", 32'({m1_ack, m0_ack}), 32'h0);
      check("abort_quiet_bc_we", 32'(bc_we), 32'h0);
      check("abort_quiet_gnt", 32'(gnt), 32'h0);
    end
    txn(1, 1, 32'h500, 32'h5, 0, 32'h600, 32'h6, 0, 32'h0BAD_F00D, 0, 0);
    check("abort_tie_m0", 32'(m_last), 32'h0);

    // Random transactions
    for (int n = 0; n < 24; n++) begin
      bit r0, r1;
      int gap;
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1'b1;
      txn(r0, r1, $urandom, $urandom, 1'($urandom_range(0, 1)),
          $urandom, $urandom, 1'($urandom_range(0, 1)),
          $urandom, 0, 1'($urandom_range(0, 3) == 0));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        cyc();
        check("rand_gap_gnt", 32'(gnt), 32'h0);
      end
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
